// File: rtl/network_controller.sv
// rtl/network_controller.sv - four-input Q-format neuron: MAC over a 4-entry register file, scale, saturate, threshold
// Optional ReLU activation: define NETWORK_CONTROLLER_RELU_EN.
module network_controller #(
  parameter int                 FRAC_BITS = 8,
  parameter logic signed [15:0] THRESHOLD = 16'sd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] write_data,
  input  logic [1:0]  write_addr,
  input  logic        write_en,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        fire
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [31:0]        rf [4];
  logic signed [33:0] acc;
  logic [1:0]         idx;

  logic signed [15:0] x_op;
  logic signed [15:0] w_op;
  logic signed [31:0] prod;
  logic signed [33:0] shifted;
  logic signed [15:0] sat_val;
  logic signed [15:0] act_val;

  assign x_op    = rf[idx][31:16];
  assign w_op    = rf[idx][15:0];
  assign prod    = x_op * w_op;
  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[15:0];
    if (shifted > 34'sd32767) begin
      sat_val = 16'sh7fff;
    end else if (shifted < -34'sd32768) begin
      sat_val = 16'sh8000;
    end
  end

  always_comb begin
`ifdef NETWORK_CONTROLLER_RELU_EN
    act_val = sat_val[15] ? 16'sd0 : sat_val;
`else
    act_val = sat_val;
`endif
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      fire   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write on the same edge as start lands before ACC reads entry 0.
          if (write_en) begin
            rf[write_addr] <= write_data;
          end
          if (start) begin
            state <= ACC;
            acc   <= '0;
            idx   <= '0;
          end
        end
        ACC: begin
          acc <= acc + $signed({{2{prod[31]}}, prod});
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          result <= act_val;
          fire   <= (act_val > THRESHOLD);
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_controller.sv
// tb/tb_network_controller.sv - randomized self-checking bench for network_controller against an arithmetic model
module tb_network_controller;

  localparam int                 FRAC = 8;
  localparam logic signed [15:0] THR  = 16'sd0;

  logic        clk;
  logic        reset;
  logic [31:0] write_data;
  logic [1:0]  write_addr;
  logic        write_en;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        fire;

  int vectors;
  int miscompares;
  logic [31:0] model_rf [4];

  network_controller #(.FRAC_BITS(FRAC), .THRESHOLD(THR)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .write_addr (write_addr),
    .write_en   (write_en),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .fire       (fire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_eval(output logic [15:0] r, output logic f);
    longint acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc += longint'($signed(model_rf[i][31:16])) * longint'($signed(model_rf[i][15:0]));
    end
    acc = acc >>> FRAC;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef NETWORK_CONTROLLER_RELU_EN
    if (acc < 0) acc = 0;
`endif
    r = acc[15:0];
    f = (acc > longint'(THR));
  endfunction

  task automatic write_word(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_en   = 1'b1;
    write_addr = addr;
    write_data = data;
    @(negedge clk);
    write_en   = 1'b0;
    model_rf[addr] = data;
  endtask

  task automatic load_all(input logic [31:0] data);
    for (int i = 0; i < 4; i++) write_word(2'(i), data);
  endtask

  // co_write: write on the start cycle; disturb: write + start during ACC (both must be ignored)
  task automatic run_eval(input string tag, input bit co_write, input logic [1:0] caddr,
                          input logic [31:0] cdata, input bit disturb);
    logic [15:0] exp_r;
    logic        exp_f;
    int          done_at;
    int          done_cnt;
    int          busy_cnt;
    @(negedge clk);
    start = 1'b1;
    if (co_write) begin
      write_en   = 1'b1;
      write_addr = caddr;
      write_data = cdata;
      model_rf[caddr] = cdata;
    end
    @(negedge clk);
    start    = 1'b0;
    write_en = 1'b0;
    model_eval(exp_r, exp_f);
    busy_cnt = busy ? 1 : 0;
    done_at  = -1;
    done_cnt = done ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (disturb && k == 2) begin
        write_en   = 1'b1;
        write_addr = 2'd0;
        write_data = 32'h0;
        start      = 1'b1;
      end else begin
        write_en = 1'b0;
        start    = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(done_at), 32'd5);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_fire"}, 32'(fire), 32'(exp_f));
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    write_en    = 1'b0;
    write_addr  = 2'd0;
    write_data  = 32'h0;
    for (int i = 0; i < 4; i++) model_rf[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_fire", 32'(fire), 32'd0);
    reset = 1'b1;

    load_all(32'h01000200);
    run_eval("basic", 1'b0, 2'd0, 32'h0, 1'b0);
    check("basic_const", 32'(result), 32'h0800);
    check("basic_fire_const", 32'(fire), 32'd1);

    load_all(32'h0100FE00);
    run_eval("neg", 1'b0, 2'd0, 32'h0, 1'b0);
`ifdef NETWORK_CONTROLLER_RELU_EN
    check("neg_const", 32'(result), 32'h0000);
`else
    check("neg_const", 32'(result), 32'h0000F800);
`endif

    load_all(32'h7FFF7FFF);
    run_eval("possat", 1'b0, 2'd0, 32'h0, 1'b0);
    check("possat_const", 32'(result), 32'h7FFF);

    load_all(32'h80007FFF);
    run_eval("negsat", 1'b0, 2'd0, 32'h0, 1'b0);

    load_all(32'h01000200);
    run_eval("busy_ignore", 1'b0, 2'd0, 32'h0, 1'b1);
    check("busy_ignore_const", 32'(result), 32'h0800);
    write_en = 1'b0;
    start    = 1'b0;
    run_eval("rerun", 1'b0, 2'd0, 32'h0, 1'b0);
    check("rerun_const", 32'(result), 32'h0800);

    run_eval("cowrite", 1'b1, 2'd2, 32'hFF000300, 1'b0);

    // Abort an evaluation with reset after E2.
    load_all(32'h01000200);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_fire", 32'(fire), 32'd0);
    for (int i = 0; i < 4; i++) model_rf[i] = 32'h0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_eval("post_reset", 1'b0, 2'd0, 32'h0, 1'b0);
    check("post_reset_const", 32'(result), 32'h0000);

    for (int n = 0; n < 25; n++) begin
      int nw;
      logic [31:0] d;
      nw = int'($urandom_range(1, 4));
      for (int j = 0; j < nw; j++) begin
        d = $urandom;
        if ($urandom_range(0, 2) == 0) d = {16'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000), d[15:0]};
        write_word(2'($urandom_range(0, 3)), d);
      end
      run_eval($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/network_controller.md
NETWORK_CONTROLLER -- requirements
Module: network_controller

Interface
REQ-001 Parameter FRAC_BITS, default 8: fractional bits of Q-format operands; accumulator shifted right by this amount before output.
REQ-002 Parameter THRESHOLD, default 16'sd0: signed firing threshold compared against result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 write_data  input  32  word from ROM stage; [31:16] signed input x, [15:0] signed weight w.
REQ-006 write_addr  input  2  register-file index for write_data.
REQ-007 write_en  input  1  single-cycle write strobe.
REQ-008 start  input  1  single-cycle pulse requesting one neuron evaluation.
REQ-009 busy  output  1  high while evaluation in progress.
REQ-010 done  output  1  one-cycle pulse, result and fire valid.
REQ-011 result  output  16  signed saturated neuron output.
REQ-012 fire  output  1  result > THRESHOLD, signed compare.

Function
REQ-013 Register file SHALL hold 4 x 32-bit entries; write_en in IDLE writes write_data to entry write_addr at that edge.
REQ-014 write_en in any state other than IDLE SHALL be ignored (no entry modified).
REQ-015 FSM states SHALL be IDLE, ACC, SCALE, DONE; undefined encodings go to IDLE.
REQ-016 IDLE -> ACC when start sampled high at edge E0; accumulator cleared and index cleared at E0; busy high from E0.
REQ-017 ACC SHALL last exactly 4 cycles; edges E1..E4 add signed x[i]*w[i] (32-bit product) for i=0..3 into a 34-bit signed accumulator; ACC -> SCALE at E4.
REQ-018 SCALE: at E5 result register loaded and state -> DONE; done high for the single cycle E5..E6; DONE -> IDLE at E6, busy low from E6.
REQ-019 Latency: done rises exactly 5 clock edges after the edge sampling start.
REQ-020 Scaling: accumulator arithmetic-shifted right by FRAC_BITS (truncation toward minus infinity), then saturated to [-32768, 32767].
REQ-021 fire SHALL be registered at E5 together with result.
REQ-022 result and fire SHALL hold their values until the next E5 or reset.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 start and write_en in the same IDLE cycle: write completes at E0 and the written value is used by the evaluation.
REQ-025 Register-file contents SHALL persist across evaluations until overwritten or reset.

Reset
REQ-026 reset low SHALL immediately force state IDLE, busy=0, done=0, result=0, fire=0, accumulator=0, index=0, all register-file entries=0.
REQ-027 reset asserted mid-evaluation SHALL abort it; no done pulse issued for the aborted evaluation.

Configuration
REQ-028 Macro NETWORK_CONTROLLER_RELU_EN: when defined, saturated value below 0 SHALL be replaced by 0 before registering result (ReLU); fire uses the clamped value.
REQ-029 Without NETWORK_CONTROLLER_RELU_EN, result SHALL be the signed saturated value unmodified (linear activation).

Verification
REQ-030 Write 0x01000200 to entries 0..3, pulse start -> done exactly 5 edges later, result=0x0800, fire=1, busy high 6 cycles.
REQ-031 Write 0x0100FE00 to entries 0..3, start -> without RELU_EN result=0xF800, fire=0; with RELU_EN result=0x0000, fire=0.
REQ-032 Write 0x7FFF7FFF to entries 0..3, start -> result=0x7FFF (positive saturation), fire=1.
REQ-033 Load REQ-030 values, start, during ACC pulse write_en addr 0 data 0x00000000 and a second start -> single done, result=0x0800; rerun -> result=0x0800 again.
REQ-034 Load REQ-030 values, start, assert reset at E2 -> busy=0, done never pulses, result=0; after release, start -> result=0x0000, fire=0.
